// File: rtl/fpu_result_buffer.sv
// fpu_result_buffer
//
// Buffers completed FPU results for a downstream consumer. Each result is
// stored together with its status flags in a small first-word-fall-through
// FIFO. The head entry is classified as zero or negative. The block also
// keeps a sticky OR of all accepted status flags, and a saturating count of
// results that were lost because the buffer was full.
//
// Result format: [31] sign, [30:25] exponent (bias 31), [24:0] fraction.
//
// Ports
//   clock          system clock
//   reset          asynchronous active-low reset
//   in_valid       FPU result valid (one-cycle pulse per operation)
//   data_in        FPU result
//   status_in      FPU status flags
//   in_ready       buffer not full
//   out_valid      head entry valid
//   out_ready      consumer accepts head
//   data_out       head result (0 when empty)
//   status_out     head status (0 when empty)
//   out_zero       head exponent and fraction both zero, either sign
//   out_neg        head sign set and head not zero
//   count          current occupancy
//   sticky_status  OR of status of accepted writes since reset/clear
//   clear_sticky   synchronous clear of sticky_status and drop_cnt
//   drop_err       one-cycle pulse after a result is dropped
//   drop_cnt       saturating count of dropped results

module fpu_result_buffer #(
    parameter int DEPTH  = 4,
    parameter int DROP_W = 8
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     in_valid,
    input  logic [31:0]              data_in,
    input  logic [3:0]               status_in,
    output logic                     in_ready,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [31:0]              data_out,
    output logic [3:0]               status_out,
    output logic                     out_zero,
    output logic                     out_neg,
    output logic [$clog2(DEPTH):0]   count,
    output logic [3:0]               sticky_status,
    input  logic                     clear_sticky,
    output logic                     drop_err,
    output logic [DROP_W-1:0]        drop_cnt
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [31:0]       data_mem_q   [DEPTH];
    logic [3:0]        status_mem_q [DEPTH];

    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [3:0]        sticky_q, sticky_d;
    logic              drop_err_q, drop_err_d;
    logic [DROP_W-1:0] drop_cnt_q, drop_cnt_d;

    logic              full;
    logic              empty;
    logic              wr_en;
    logic              rd_en;
    logic              drop;
    logic [31:0]       head_data;
    logic [3:0]        head_status;

    assign full  = (count_q == CNT_W'(DEPTH));
    assign empty = (count_q == '0);

    // A full buffer refuses the write even when a read frees a slot on the
    // same edge; in_ready depends only on registered state.
    assign wr_en = in_valid && !full;
    assign rd_en = out_ready && !empty;
    assign drop  = in_valid && full;

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        sticky_d   = sticky_q;
        drop_err_d = drop;
        drop_cnt_d = drop_cnt_q;

        if (wr_en) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (rd_en) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end

        case ({wr_en, rd_en})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase

        // Clear and a same-edge event combine: the event lands on a
        // freshly cleared value.
        if (clear_sticky) begin
            sticky_d   = wr_en ? status_in : 4'b0000;
            drop_cnt_d = drop ? DROP_W'(1) : '0;
        end else begin
            if (wr_en) begin
                sticky_d = sticky_q | status_in;
            end
            if (drop && (drop_cnt_q != '1)) begin
                drop_cnt_d = drop_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            sticky_q   <= '0;
            drop_err_q <= 1'b0;
            drop_cnt_q <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            sticky_q   <= sticky_d;
            drop_err_q <= drop_err_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    // Storage is deliberately not reset; occupancy tracking masks stale data.
    always_ff @(posedge clock) begin
        if (reset && wr_en) begin
            data_mem_q[wr_ptr_q]   <= data_in;
            status_mem_q[wr_ptr_q] <= status_in;
        end
    end

    assign head_data   = empty ? 32'h0 : data_mem_q[rd_ptr_q];
    assign head_status = empty ? 4'h0  : status_mem_q[rd_ptr_q];

    assign in_ready      = !full;
    assign out_valid     = !empty;
    assign data_out      = head_data;
    assign status_out    = head_status;
    // Zero ignores the sign bit, so -0 is zero and never negative.
    assign out_zero      = !empty && (head_data[30:0] == 31'h0);
    assign out_neg       = head_data[31] && !out_zero;
    assign count         = count_q;
    assign sticky_status = sticky_q;
    assign drop_err      = drop_err_q;
    assign drop_cnt      = drop_cnt_q;

endmodule

// File: tb/tb_fpu_result_buffer.sv
module tb_fpu_result_buffer;

    logic        clock;
    logic        reset;
    logic        in_valid;
    logic [31:0] data_in;
    logic [3:0]  status_in;
    logic        in_ready;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] data_out;
    logic [3:0]  status_out;
    logic        out_zero;
    logic        out_neg;
    logic [2:0]  count;
    logic [3:0]  sticky_status;
    logic        clear_sticky;
    logic        drop_err;
    logic [7:0]  drop_cnt;

    int checks = 0;
    int errors = 0;

    fpu_result_buffer #(.DEPTH(4), .DROP_W(8)) dut (
        .clock         (clock),
        .reset         (reset),
        .in_valid      (in_valid),
        .data_in       (data_in),
        .status_in     (status_in),
        .in_ready      (in_ready),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .data_out      (data_out),
        .status_out    (status_out),
        .out_zero      (out_zero),
        .out_neg       (out_neg),
        .count         (count),
        .sticky_status (sticky_status),
        .clear_sticky  (clear_sticky),
        .drop_err      (drop_err),
        .drop_cnt      (drop_cnt)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle();
        in_valid     = 1'b0;
        out_ready    = 1'b0;
        clear_sticky = 1'b0;
        data_in      = 32'h0;
        status_in    = 4'h0;
    endtask

    task automatic push(input logic [31:0] d, input logic [3:0] s);
        in_valid  = 1'b1;
        data_in   = d;
        status_in = s;
        tick();
        idle();
    endtask

    task automatic pop();
        out_ready = 1'b1;
        tick();
        idle();
    endtask

    initial begin
        reset = 1'b0;
        idle();
        #22;
        check("rst_out_valid", 32'(out_valid), 32'h0);
        check("rst_count", 32'(count), 32'h0);
        check("rst_data_out", data_out, 32'h0);
        check("rst_status_out", 32'(status_out), 32'h0);
        check("rst_zero", 32'(out_zero), 32'h0);
        check("rst_neg", 32'(out_neg), 32'h0);
        check("rst_sticky", 32'(sticky_status), 32'h0);
        check("rst_drop_err", 32'(drop_err), 32'h0);
        check("rst_drop_cnt", 32'(drop_cnt), 32'h0);
        check("rst_in_ready", 32'(in_ready), 32'h1);
        reset = 1'b1;
        tick();

        // 1: single write appears after the edge
        push(32'h4000_0000, 4'b0001);
        check("t1_valid", 32'(out_valid), 32'h1);
        check("t1_data", data_out, 32'h4000_0000);
        check("t1_status", 32'(status_out), 32'h1);
        check("t1_zero", 32'(out_zero), 32'h0);
        check("t1_neg", 32'(out_neg), 32'h0);
        check("t1_count", 32'(count), 32'h1);
        check("t1_sticky", 32'(sticky_status), 32'h1);

        // 2: zero and negative classification
        push(32'h0000_0000, 4'b0000);
        push(32'hBE00_0000, 4'b0000);
        check("t2_count3", 32'(count), 32'h3);
        check("t2_head_hold", data_out, 32'h4000_0000);
        pop();
        check("t2_zero_data", data_out, 32'h0000_0000);
        check("t2_zero", 32'(out_zero), 32'h1);
        check("t2_zero_valid", 32'(out_valid), 32'h1);
        check("t2_count2", 32'(count), 32'h2);
        pop();
        check("t2_neg_data", data_out, 32'hBE00_0000);
        check("t2_neg", 32'(out_neg), 32'h1);
        check("t2_neg_zero", 32'(out_zero), 32'h0);
        check("t2_count1", 32'(count), 32'h1);
        pop();
        check("t2_empty_valid", 32'(out_valid), 32'h0);
        pop();
        check("t2_empty_pop_count", 32'(count), 32'h0);
        push(32'h8000_0000, 4'b0000);
        check("t2_negzero_zero", 32'(out_zero), 32'h1);
        check("t2_negzero_neg", 32'(out_neg), 32'h0);
        pop();

        // 3: fill, drop, drain
        for (int i = 0; i < 4; i++) push(32'h3E00_0000, 4'b0000);
        check("t3_full_count", 32'(count), 32'h4);
        check("t3_full_ready", 32'(in_ready), 32'h0);
        push(32'h4000_0000, 4'b0010);
        check("t3_drop_err", 32'(drop_err), 32'h1);
        check("t3_drop_cnt", 32'(drop_cnt), 32'h1);
        check("t3_sticky", 32'(sticky_status), 32'h1);
        check("t3_count_kept", 32'(count), 32'h4);
        tick();
        check("t3_drop_err_end", 32'(drop_err), 32'h0);
        for (int i = 0; i < 4; i++) begin
            check("t3_drain_data", data_out, 32'h3E00_0000);
            pop();
        end
        check("t3_drained_valid", 32'(out_valid), 32'h0);
        check("t3_drained_data", data_out, 32'h0);
        check("t3_drained_count", 32'(count), 32'h0);

        // 4: simultaneous read/write with pointer wrap, then at full
        push(32'h1111_1111, 4'b0000);
        push(32'h2222_2222, 4'b0000);
        in_valid = 1'b1; out_ready = 1'b1; data_in = 32'h3333_3333;
        tick();
        check("t4_rw1_count", 32'(count), 32'h2);
        check("t4_rw1_head", data_out, 32'h2222_2222);
        data_in = 32'h4444_4444;
        tick();
        check("t4_rw2_count", 32'(count), 32'h2);
        check("t4_rw2_head", data_out, 32'h3333_3333);
        data_in = 32'h5555_5555;
        tick();
        idle();
        check("t4_rw3_count", 32'(count), 32'h2);
        check("t4_rw3_head", data_out, 32'h4444_4444);
        push(32'h6666_6666, 4'b0000);
        push(32'h7777_7777, 4'b0000);
        check("t4_full_count", 32'(count), 32'h4);
        in_valid = 1'b1; out_ready = 1'b1; data_in = 32'h8888_8888; status_in = 4'b1000;
        tick();
        idle();
        check("t4_fullrw_count", 32'(count), 32'h3);
        check("t4_fullrw_drop_cnt", 32'(drop_cnt), 32'h2);
        check("t4_fullrw_drop_err", 32'(drop_err), 32'h1);
        check("t4_fullrw_sticky", 32'(sticky_status), 32'h1);
        check("t4_fullrw_head", data_out, 32'h5555_5555);
        pop();
        check("t4_d1", data_out, 32'h6666_6666);
        pop();
        check("t4_d2", data_out, 32'h7777_7777);
        pop();
        check("t4_empty", 32'(out_valid), 32'h0);

        // 5: sticky accumulation, clear, drop saturation
        clear_sticky = 1'b1;
        tick();
        idle();
        check("t5_clr_sticky", 32'(sticky_status), 32'h0);
        check("t5_clr_drop_cnt", 32'(drop_cnt), 32'h0);
        push(32'h3F00_0000, 4'b0100);
        push(32'h3F00_0000, 4'b1000);
        check("t5_sticky_acc", 32'(sticky_status), 32'hC);
        clear_sticky = 1'b1;
        push(32'h3F00_0000, 4'b0001);
        check("t5_clr_wr_sticky", 32'(sticky_status), 32'h1);
        check("t5_clr_wr_drop_cnt", 32'(drop_cnt), 32'h0);
        check("t5_clr_wr_count", 32'(count), 32'h3);
        push(32'h3F00_0000, 4'b0000);
        in_valid = 1'b1; status_in = 4'b1111;
        for (int i = 0; i < 260; i++) tick();
        idle();
        check("t5_sat_drop_cnt", 32'(drop_cnt), 32'hFF);
        check("t5_sat_sticky", 32'(sticky_status), 32'h1);
        in_valid = 1'b1; clear_sticky = 1'b1;
        tick();
        idle();
        check("t5_clr_drop_cnt1", 32'(drop_cnt), 32'h1);
        check("t5_clr_drop_sticky", 32'(sticky_status), 32'h0);
        pop();
        in_valid = 1'b1; out_ready = 1'b1; data_in = 32'h3F80_0000; status_in = 4'b0010;
        tick();
        idle();
        check("t5_pre_rst_count", 32'(count), 32'h3);
        check("t5_pre_rst_sticky", 32'(sticky_status), 32'h2);

        // 6: asynchronous reset mid-cycle
        #2;
        reset = 1'b0;
        #1;
        check("t6_rst_valid", 32'(out_valid), 32'h0);
        check("t6_rst_count", 32'(count), 32'h0);
        check("t6_rst_sticky", 32'(sticky_status), 32'h0);
        check("t6_rst_drop_cnt", 32'(drop_cnt), 32'h0);
        check("t6_rst_data", data_out, 32'h0);
        #2;
        reset = 1'b1;
        check("t6_rel_ready", 32'(in_ready), 32'h1);
        push(32'h3E00_0000, 4'b0000);
        check("t6_new_head", data_out, 32'h3E00_0000);
        check("t6_new_count", 32'(count), 32'h1);
        check("t6_new_valid", 32'(out_valid), 32'h1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fpu_result_buffer.md
Name: fpu_result_buffer

Overview:
- Downstream stage of the FPU: captures each completed result (data_out/status_out) and holds it for a consumer.
- Consumer interface uses valid/ready.
- Functions:
  - DEPTH-entry first-word-fall-through FIFO of {result, status}.
  - Per-entry classification: zero and negative.
  - Sticky OR of all status flags accepted since the last clear.
  - Saturating count of results dropped while the buffer was full.
- Result format is the FPU format: [31] sign, [30:25] exponent (bias 31), [24:0] fraction.

Parameters:
- DEPTH, 4, number of entries; power of two, 2..16.
- DROP_W, 8, width of the drop counter.

Ports:
- clock  in  1  system clock (100 kHz in system).
- reset  in  1  asynchronous, active-low reset.
- in_valid  in  1  FPU result valid (one-cycle pulse per completed operation).
- data_in  in  32  FPU result.
- status_in  in  4  FPU status flags.
- in_ready  out  1  buffer can accept (not full).
- out_valid  out  1  head entry valid.
- out_ready  in  1  consumer accepts head.
- data_out  out  32  head result.
- status_out  out  4  head status.
- out_zero  out  1  head exponent==0 and fraction==0 (either sign).
- out_neg  out  1  head sign bit set and not out_zero.
- count  out  $clog2(DEPTH)+1  current occupancy.
- sticky_status  out  4  OR of status of all accepted writes since reset/clear.
- clear_sticky  in  1  synchronous clear of sticky_status and drop_cnt.
- drop_err  out  1  one-cycle pulse when a result is dropped.
- drop_cnt  out  DROP_W  saturating count of dropped results.

Behaviour:
- Reset (reset=0, async): pointers and count=0; out_valid=0; data_out=0; status_out=0; out_zero=0; out_neg=0; sticky_status=0; drop_err=0; drop_cnt=0. Storage array is not reset. Inputs are ignored while reset is low.
- in_ready = (count != DEPTH), combinational from registered state; high immediately after reset.
- Write: in_valid && in_ready at a rising edge → store {data_in, status_in} at the write pointer; write pointer wraps modulo DEPTH.
- Read: out_valid && out_ready at a rising edge → advance the read pointer (wraps modulo DEPTH).
- out_valid = (count != 0).
- data_out, status_out, out_zero and out_neg are combinational from the head entry. When empty they are forced to 0.
- Latency: a result written at edge N is on data_out with out_valid=1 after edge N. There is no same-cycle bypass.
- Simultaneous read and write:
  - Not full: both happen; count unchanged.
  - Full: in_ready=0, so only the read happens; the incoming result is dropped even though a slot frees at that edge.
- Empty plus out_ready: no effect.
- Drop: in_valid && !in_ready → drop_err=1 for exactly the next cycle; drop_cnt increments and saturates at 2^DROP_W-1.
- Sticky: on every accepted write, sticky_status |= status_in. Dropped results do not update sticky.
- clear_sticky=1:
  - sticky_status is cleared to 0 and drop_cnt to 0.
  - A write on the same edge sets sticky_status = status_in.
  - A drop on the same edge sets drop_cnt = 1.
- Classification is sign-agnostic for zero: 0x80000000 gives out_zero=1, out_neg=0. Other encodings are not special-cased (no inf/NaN decode).
- Reset asserted mid-operation: buffered contents are discarded; the FIFO is empty on release.

Test Plan:
1. Reset, then in_valid pulse with data_in=0x40000000 (2.0), status_in=4'b0001 → next cycle: out_valid=1, data_out=0x40000000, out_zero=0, out_neg=0, count=1, sticky_status=4'b0001.
2. Write 0x00000000 (1.0 + -1.0 result) and 0xBE000000 (-1.0), each with status 4'b0000; hold out_ready=0 → entry 1 shows out_zero=1. Pulse out_ready → head becomes 0xBE000000 with out_neg=1; count 2→1.
3. Fill to DEPTH=4 (0x3E000000 ×4), then write 0x40000000 with status 4'b0010 → in_ready=0, drop_err pulse, drop_cnt=1, sticky_status unchanged. Drain all four entries → 0x3E000000 four times, then out_valid=0, data_out=0.
4. With count=2, assert in_valid and out_ready on the same edge → count stays 2 and the pointers wrap past DEPTH-1 correctly. Then set count=DEPTH and repeat → read only, count=DEPTH-1, drop_cnt increments.
5. Write status 4'b0100, then 4'b1000 → sticky_status=4'b1100. Assert clear_sticky together with a write of status 4'b0001 → sticky_status=4'b0001, drop_cnt=0.
6. With 3 entries held, drive reset low mid-cycle (asynchronously) → out_valid, count and sticky_status are 0 immediately. After release, in_ready=1 and a new write 0x3E000000 appears as the head.
